// File: rtl/mmio_bridge_pkg.sv
// mmio_bridge_pkg: register map offsets, window geometry and the STATUS word layout.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package mmio_bridge_pkg;

  localparam int MAX_CH       = 16;
  localparam int WIN_WORDS    = 64;

  localparam int OFF_OUT      = 0;
  localparam int OFF_IN       = 16;
  localparam int OFF_STATUS   = 32;
  localparam int OFF_CLEAR    = 33;
  localparam int OFF_IRQ_MASK = 34;

  typedef struct packed {
    logic [MAX_CH-1:0] ovf;
    logic [MAX_CH-1:0] nw;
  } status_t;

endpackage

// File: rtl/mmio_bridge_if.sv
// mmio_bridge_if: processor dmem port plus the RAM-side write enable / read data.
// Latency: n/a (wiring only).
// Backpressure: none; the dmem port has no stall.
interface mmio_bridge_if #(
  parameter int DATA_W = 32
);

  logic              cpu_wren;
  logic [31:0]       cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              ram_wren;
  logic [DATA_W-1:0] ram_rdata;

  // master is the processor + RAM side, slave is the bridge
  modport master (
    output cpu_wren, cpu_addr, cpu_wdata, ram_rdata,
    input  cpu_rdata, ram_wren
  );

  modport slave (
    input  cpu_wren, cpu_addr, cpu_wdata, ram_rdata,
    output cpu_rdata, ram_wren
  );

endinterface

// File: rtl/mmio_in_channel.sv
// mmio_in_channel: one peripheral-written register with sticky NEW/OVF flags.
// Latency: capture and flag updates land on the next clock edge.
// Backpressure: none; a capture strobe always overwrites the held value.
module mmio_in_channel
  import mmio_bridge_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cap_vld,
  input  logic [DATA_W-1:0] cap_dat,
  input  logic              rd_clr,
  input  logic              w1c_new,
  input  logic              w1c_ovf,
  output logic [DATA_W-1:0] val_q,
  output logic              new_q,
  output logic              ovf_q
);

  logic clr_new;

  assign clr_new = rd_clr | w1c_new;

  // A capture always wins over a clear of NEW; OVF only sets when unread data is lost.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      val_q <= '0;
      new_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      if (cap_vld) begin
        val_q <= cap_dat;
      end

      if (cap_vld) begin
        new_q <= 1'b1;
      end else if (clr_new) begin
        new_q <= 1'b0;
      end

      if (cap_vld && new_q && !clr_new) begin
        ovf_q <= 1'b1;
      end else if (w1c_ovf) begin
        ovf_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/mmio_bridge.sv
// mmio_bridge: register window on the dmem port (OUT/IN/STATUS/CLEAR), irq via MMIO_BRIDGE_IRQ_EN.
// Latency: writes visible next cycle; reads return 1 cycle later, aligned with RAM.
// Backpressure: none; every access completes in a single cycle.
module mmio_bridge
  import mmio_bridge_pkg::*;
#(
  parameter int          DATA_W    = 32,
  parameter int          NUM_OUT   = 4,
  parameter int          NUM_IN    = 4,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0F00
) (
  input  logic                      clock,
  input  logic                      reset,
  mmio_bridge_if.slave              bus,
  output logic [NUM_OUT*DATA_W-1:0] out_regs,
  input  logic [NUM_IN*DATA_W-1:0]  in_data,
  input  logic [NUM_IN-1:0]         in_valid,
  output logic                      irq
);

  if (NUM_OUT < 1 || NUM_OUT > MAX_CH) begin : g_bad_num_out
    $error("mmio_bridge: NUM_OUT must be 1..16");
  end
  if (NUM_IN < 1 || NUM_IN > MAX_CH) begin : g_bad_num_in
    $error("mmio_bridge: NUM_IN must be 1..16");
  end
  if (BASE_ADDR % 32'(WIN_WORDS) != 32'd0) begin : g_bad_base
    $error("mmio_bridge: BASE_ADDR must be a multiple of 64");
  end
  if (DATA_W < 32) begin : g_bad_width
    $error("mmio_bridge: DATA_W must hold the 32-bit STATUS word");
  end

  logic                           hit;
  logic                           wr;
  logic                           rd;
  logic                           clr_wr;
  logic [5:0]                     off;
  logic [NUM_OUT-1:0][DATA_W-1:0] out_q;
  logic [NUM_IN-1:0][DATA_W-1:0]  ch_val;
  logic [NUM_IN-1:0]              ch_new;
  logic [NUM_IN-1:0]              ch_ovf;
  logic [NUM_IN-1:0]              rd_clr;
  status_t                        status;
  logic [DATA_W-1:0]              rd_mux;
  logic [DATA_W-1:0]              mmio_q;
  logic                           rd_hit_q;

  assign hit          = (bus.cpu_addr[31:6] == BASE_ADDR[31:6]);
  assign off          = bus.cpu_addr[5:0];
  assign wr           = bus.cpu_wren & hit;
  // The port has no read strobe: any non-write access inside the window is a read.
  assign rd           = ~bus.cpu_wren & hit;
  assign clr_wr       = wr && (off == 6'(OFF_CLEAR));
  assign bus.ram_wren = bus.cpu_wren & ~hit;
  assign out_regs     = out_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_q <= '0;
    end else if (wr) begin
      for (int i = 0; i < NUM_OUT; i++) begin
        if (off == 6'(OFF_OUT + i)) begin
          out_q[i] <= bus.cpu_wdata;
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_IN; g++) begin : g_in
    assign rd_clr[g] = rd && (off == 6'(OFF_IN + g));

    mmio_in_channel #(
      .DATA_W (DATA_W)
    ) u_ch (
      .clock   (clock),
      .reset   (reset),
      .cap_vld (in_valid[g]),
      .cap_dat (in_data[g*DATA_W +: DATA_W]),
      .rd_clr  (rd_clr[g]),
      .w1c_new (clr_wr & bus.cpu_wdata[g]),
      .w1c_ovf (clr_wr & bus.cpu_wdata[MAX_CH + g]),
      .val_q   (ch_val[g]),
      .new_q   (ch_new[g]),
      .ovf_q   (ch_ovf[g])
    );
  end

  always_comb begin
    status                = '0;
    status.nw[NUM_IN-1:0]  = ch_new;
    status.ovf[NUM_IN-1:0] = ch_ovf;
  end

`ifdef MMIO_BRIDGE_IRQ_EN
  logic [MAX_CH-1:0] irq_mask_q;
  logic              irq_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      irq_mask_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      if (wr && (off == 6'(OFF_IRQ_MASK))) begin
        irq_mask_q <= bus.cpu_wdata[MAX_CH-1:0];
      end
      irq_q <= |(ch_new & irq_mask_q[NUM_IN-1:0]);
    end
  end

  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NUM_OUT; i++) begin
      if (off == 6'(OFF_OUT + i)) rd_mux = out_q[i];
    end
    for (int i = 0; i < NUM_IN; i++) begin
      if (off == 6'(OFF_IN + i)) rd_mux = ch_val[i];
    end
    if (off == 6'(OFF_STATUS)) rd_mux = DATA_W'(status);
`ifdef MMIO_BRIDGE_IRQ_EN
    if (off == 6'(OFF_IRQ_MASK)) rd_mux = DATA_W'(irq_mask_q);
`endif
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_hit_q <= 1'b0;
      mmio_q   <= '0;
    end else begin
      rd_hit_q <= hit;
      mmio_q   <= rd_mux;
    end
  end

  assign bus.cpu_rdata = rd_hit_q ? mmio_q : bus.ram_rdata;

endmodule

// File: tb/tb_mmio_bridge.sv
// tb_mmio_bridge: directed vector table plus hand sequences for reset and irq timing.
// Drives at negedge, samples #1 after posedge; RAM model returns {16'hAAAA, addr[15:0]}.
module tb_mmio_bridge;
  import mmio_bridge_pkg::*;

  localparam int          DW = 32;
  localparam int          NO = 4;
  localparam int          NI = 4;
  localparam logic [31:0] B  = 32'h0000_0F00;
`ifdef MMIO_BRIDGE_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif

  typedef struct {
    logic        wren;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  iv;
    logic [31:0] idat;
    logic        chk_rd;
    logic [31:0] exp_rd;
    logic        exp_ramw;
    int          oidx;
    logic [31:0] exp_out;
  } vec_t;

  logic              clock = 1'b0;
  logic              reset;
  logic [NO*DW-1:0]  out_regs;
  logic [NI*DW-1:0]  in_data;
  logic [NI-1:0]     in_valid;
  logic              irq;
  int                n_vec = 0;
  int                n_bad = 0;
  vec_t              vq[$];

  always #5 clock = ~clock;

  mmio_bridge_if #(.DATA_W(DW)) bus();

  mmio_bridge #(
    .DATA_W    (DW),
    .NUM_OUT   (NO),
    .NUM_IN    (NI),
    .BASE_ADDR (B)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .bus      (bus),
    .out_regs (out_regs),
    .in_data  (in_data),
    .in_valid (in_valid),
    .irq      (irq)
  );

  always @(posedge clock) bus.ram_rdata <= {16'hAAAA, bus.cpu_addr[15:0]};

  function automatic vec_t mk(input logic wren, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [3:0] iv, input logic [31:0] idat, input logic chk_rd,
                              input logic [31:0] exp_rd, input logic exp_ramw, input int oidx,
                              input logic [31:0] exp_out);
    vec_t v;
    v.wren = wren; v.addr = addr; v.wdata = wdata; v.iv = iv; v.idat = idat;
    v.chk_rd = chk_rd; v.exp_rd = exp_rd; v.exp_ramw = exp_ramw;
    v.oidx = oidx; v.exp_out = exp_out;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic wren, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] iv, input logic [31:0] idat);
    bus.cpu_wren  = wren;
    bus.cpu_addr  = addr;
    bus.cpu_wdata = wdata;
    in_valid      = iv;
    in_data       = {NI{idat}};
  endtask

  task automatic apply(input string tag, input vec_t v);
    @(negedge clock);
    drive(v.wren, v.addr, v.wdata, v.iv, v.idat);
    #1 check({tag, " ram_wren"}, {31'b0, bus.ram_wren}, {31'b0, v.exp_ramw});
    @(posedge clock);
    #1;
    if (v.chk_rd) check({tag, " rdata"}, bus.cpu_rdata, v.exp_rd);
    if (v.oidx >= 0) check({tag, " out_regs"}, out_regs[v.oidx*DW +: DW], v.exp_out);
  endtask

  initial begin
    // Test 2: OUT write and out-of-window write
    vq.push_back(mk(1, B+2,  32'h0000_0123, 0, 0, 0, 0, 0, 2, 32'h0000_0123));
    vq.push_back(mk(1, B-1,  32'h0000_0055, 0, 0, 0, 0, 1, 2, 32'h0000_0123));
    vq.push_back(mk(0, B+2,  0, 0, 0, 1, 32'h0000_0123, 0, -1, 0));
    vq.push_back(mk(0, B+1,  0, 0, 0, 1, 32'h0000_0000, 0, -1, 0));
    // Test 3: capture, STATUS before/after read
    vq.push_back(mk(0, 0,    0, 4'h1, 42, 1, 32'hAAAA_0000, 0, -1, 0));
    vq.push_back(mk(0, B+32, 0, 0, 0, 1, 32'h0000_0001, 0, -1, 0));
    vq.push_back(mk(0, B+16, 0, 0, 0, 1, 32'd42, 0, -1, 0));
    vq.push_back(mk(0, B+32, 0, 0, 0, 1, 32'h0000_0000, 0, -1, 0));
    // Test 4: overflow and W1C of OVF
    vq.push_back(mk(0, 0,    0, 4'h8, 7, 0, 0, 0, -1, 0));
    vq.push_back(mk(0, 0,    0, 4'h8, 9, 0, 0, 0, -1, 0));
    vq.push_back(mk(0, B+32, 0, 0, 0, 1, 32'h0008_0008, 0, -1, 0));
    vq.push_back(mk(1, B+33, 32'h0008_0000, 0, 0, 0, 0, 0, -1, 0));
    vq.push_back(mk(0, B+32, 0, 0, 0, 1, 32'h0000_0008, 0, -1, 0));
    // Test 5: capture coincident with read
    vq.push_back(mk(0, 0,    0, 4'h2, 32'h11, 0, 0, 0, -1, 0));
    vq.push_back(mk(0, B+17, 0, 4'h2, 32'h22, 1, 32'h0000_0011, 0, -1, 0));
    vq.push_back(mk(0, B+32, 0, 0, 0, 1, 32'h0000_000A, 0, -1, 0));
    vq.push_back(mk(0, B+17, 0, 0, 0, 1, 32'h0000_0022, 0, -1, 0));
    vq.push_back(mk(0, B+32, 0, 0, 0, 1, 32'h0000_0008, 0, -1, 0));
    // capture coincident with CLEAR of NEW
    vq.push_back(mk(1, B+33, 32'h0000_0008, 4'h8, 5, 0, 0, 0, -1, 0));
    vq.push_back(mk(0, B+32, 0, 0, 0, 1, 32'h0000_0008, 0, -1, 0));
    vq.push_back(mk(0, B+19, 0, 0, 0, 1, 32'h0000_0005, 0, -1, 0));
    // unmapped, window edges, last OUT and first unused OUT slot
    vq.push_back(mk(0, B+40, 0, 0, 0, 1, 32'h0000_0000, 0, -1, 0));
    vq.push_back(mk(1, B+40, 32'h0000_FFFF, 0, 0, 0, 0, 0, -1, 0));
    vq.push_back(mk(0, B+40, 0, 0, 0, 1, 32'h0000_0000, 0, -1, 0));
    vq.push_back(mk(0, B+64, 0, 0, 0, 1, 32'hAAAA_0F40, 0, -1, 0));
    vq.push_back(mk(1, B+64, 32'h1, 0, 0, 0, 0, 1, -1, 0));
    vq.push_back(mk(1, B+3,  32'hCAFE_F00D, 0, 0, 0, 0, 0, 3, 32'hCAFE_F00D));
    vq.push_back(mk(0, B+3,  0, 0, 0, 1, 32'hCAFE_F00D, 0, -1, 0));
    vq.push_back(mk(0, B+4,  0, 0, 0, 1, 32'h0000_0000, 0, -1, 0));
    vq.push_back(mk(1, B+34, 32'h0000_FFFF, 0, 0, 0, 0, 0, -1, 0));
    vq.push_back(mk(0, B+34, 0, 0, 0, 1, IRQ_ON ? 32'h0000_FFFF : 32'h0, 0, -1, 0));

    // Test 1: reset state, then asynchronous reset mid-run
    reset = 1'b0;
    drive(0, 0, 0, 0, 0);
    repeat (2) @(posedge clock);
    #1;
    check("rst out_regs nonzero", {31'b0, out_regs != '0}, 32'h0);
    check("rst irq", {31'b0, irq}, 32'h0);
    check("rst rdata", bus.cpu_rdata, 32'hAAAA_0000);
    @(negedge clock) reset = 1'b1;
    apply("t1 wr", mk(1, B+1, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, 1, 32'hDEAD_BEEF));
    apply("t1 rd", mk(0, B+1, 0, 0, 0, 1, 32'hDEAD_BEEF, 0, -1, 0));
    @(negedge clock);
    drive(0, 0, 0, 0, 0);
    #2 reset = 1'b0;
    #1;
    check("midrst out_regs nonzero", {31'b0, out_regs != '0}, 32'h0);
    check("midrst irq", {31'b0, irq}, 32'h0);
    check("midrst rdata", bus.cpu_rdata, 32'hAAAA_0F01);
    @(negedge clock) reset = 1'b1;

    for (int k = 0; k < vq.size(); k++) begin
      apply($sformatf("v%0d", k), vq[k]);
    end

    // Test 6: irq follows NEW & mask one cycle late
    apply("t6 mask", mk(1, B+34, 32'h0000_0002, 0, 0, 0, 0, 0, -1, 0));
    apply("t6 cap", mk(0, 0, 0, 4'h2, 32'h77, 0, 0, 0, -1, 0));
    check("t6 irq at capture edge", {31'b0, irq}, 32'h0);
    apply("t6 wait", mk(0, 0, 0, 0, 0, 0, 0, 0, -1, 0));
    check("t6 irq raised", {31'b0, irq}, {31'b0, IRQ_ON});
    apply("t6 rd", mk(0, B+17, 0, 0, 0, 1, 32'h0000_0077, 0, -1, 0));
    check("t6 irq held at read edge", {31'b0, irq}, {31'b0, IRQ_ON});
    apply("t6 idle", mk(0, 0, 0, 0, 0, 0, 0, 0, -1, 0));
    check("t6 irq cleared", {31'b0, irq}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
